// File: rtl/tick_timebase_pkg.sv
// Shared types and sizing helpers for the tick timebase.
// Provides the run/pause/step state enum and divider width math.
package tick_timebase_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    STEP   = 2'd2
  } tb_state_e;

  function automatic int half_of(input int clk_hz,
                                 input int tick_hz);
    return clk_hz / (2 * tick_hz);
  endfunction

  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_timebase_btn_debounce_pulse.sv
// Button conditioner: 2-flop sync, stable-level debounce, press pulse.
// clk_i/rst_i clock+async reset, btn_i raw button, press_o 1-cycle press.
module btn_debounce_pulse
  import tick_timebase_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int DW = width_of(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_debounce_pulse: DEBOUNCE_CYCLES < 1");
  end

  logic          sync1_q, sync2_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic          done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  // Until the button has been seen stably released after reset,
  // the debouncer stays disarmed so a held button cannot fire.
  always_comb begin
    cnt_d   = '0;
    db_d    = db_q;
    armed_d = armed_q;
    press_d = 1'b0;
    done    = (cnt_q == LAST);
    if (!armed_q) begin
      if (!sync2_q) begin
        if (done) armed_d = 1'b1;
        else      cnt_d   = cnt_q + DW'(1);
      end
    end else if (sync2_q != db_q) begin
      if (done) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/tick_timebase.sv
// Run/pause/single-step square-wave timebase with debounced buttons.
// fpga_clk, sys_init_ctrl (async high reset), run_btn, step_btn in;
// clk_1Hz level, tick rise pulse, running flag out.
module tick_timebase
  import tick_timebase_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic fpga_clk,
  input  logic sys_init_ctrl,
  input  logic run_btn,
  input  logic step_btn,
  output logic clk_1Hz,
  output logic tick,
  output logic running
);

  localparam int HALF = half_of(CLK_HZ, TICK_HZ);
  localparam int W    = width_of(HALF);
  localparam logic [W-1:0] LASTC = W'(HALF - 1);

  if (HALF < 2) begin : g_bad_half
    $error("tick_timebase: HALF must be >= 2");
  end

  logic run_press, step_press;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk_i  (fpga_clk),
    .rst_i  (sys_init_ctrl),
    .btn_i  (run_btn),
    .press_o(run_press)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk_i  (fpga_clk),
    .rst_i  (sys_init_ctrl),
    .btn_i  (step_btn),
    .press_o(step_press)
  );

  tb_state_e    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         wrap;

  always_ff @(posedge fpga_clk or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) begin
      state_q <= RUN;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign wrap = (cnt_q == LASTC);

  // Run press wins over step press when both land in PAUSED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (run_press) begin
          state_d = PAUSED;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end else begin
          cnt_d = wrap ? '0 : cnt_q + W'(1);
          if (wrap) begin
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
          end
        end
      end
      PAUSED: begin
        if (run_press) begin
          state_d = RUN;
        end else if (step_press) begin
          state_d = STEP;
          cnt_d   = '0;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      STEP: begin
        if (wrap) begin
          state_d = PAUSED;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  assign clk_1Hz = clk_q;
  assign tick    = tick_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_tick_timebase.sv
// Self-checking bench for tick_timebase (HALF=10, debounce 4).
// Table vectors, directed corner sequences and a random run vs model.
module tb_tick_timebase;

  localparam int H  = 10;
  localparam int D  = 4;
  localparam int HW = D + 2;

  logic fpga_clk = 1'b0;
  logic sys_init_ctrl, run_btn, step_btn;
  logic clk_1Hz, tick, running;

  tick_timebase #(
    .CLK_HZ(20),
    .TICK_HZ(1),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .fpga_clk     (fpga_clk),
    .sys_init_ctrl(sys_init_ctrl),
    .run_btn      (run_btn),
    .step_btn     (step_btn),
    .clk_1Hz      (clk_1Hz),
    .tick         (tick),
    .running      (running)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_tests, n_fail;
  int tick_cnt, high_cnt;

  // Reference model: 0=run 1=paused 2=step; mk counts edges
  // since reset, mt0 is the edge the current run/step began.
  int mk, mt0, mst;
  bit m_armed[2], m_db[2], m_pr[2];
  bit mh[2][HW];

  typedef struct {
    int rl;
    int sl;
    int wt;
    int ticks;
    bit run;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mk = 0; mt0 = 0; mst = 0;
    for (int b = 0; b < 2; b++) begin
      m_armed[b] = 0; m_db[b] = 0; m_pr[b] = 0;
      for (int i = 0; i < HW; i++) mh[b][i] = 0;
    end
  endtask

  task automatic model_edge();
    if (sys_init_ctrl) begin
      model_reset();
    end else begin
      mk++;
      case (mst)
        0: if (m_pr[0]) mst = 1;
        1: begin
          if (m_pr[0]) begin
            mst = 0; mt0 = mk;
          end else if (m_pr[1]) begin
            mst = 2; mt0 = mk;
          end
        end
        default: if (mk - mt0 == H) mst = 1;
      endcase
      // A level is accepted once D consecutive synced samples agree.
      for (int b = 0; b < 2; b++) begin
        bit a1, a0;
        a1 = 1; a0 = 1;
        for (int i = HW - 1; i > 0; i--) mh[b][i] = mh[b][i-1];
        mh[b][0] = (b == 0) ? run_btn : step_btn;
        for (int i = 2; i < HW; i++) begin
          a1 &= mh[b][i];
          a0 &= !mh[b][i];
        end
        m_pr[b] = 0;
        if (!m_armed[b]) begin
          if (mk >= D && a0) m_armed[b] = 1;
        end else if (a1 && !m_db[b]) begin
          m_db[b] = 1; m_pr[b] = 1;
        end else if (a0 && m_db[b]) begin
          m_db[b] = 0;
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_vec();
    int n;
    if (sys_init_ctrl) return 3'b001;
    case (mst)
      0: begin
        n = mk - mt0;
        return {((n / H) % 2) == 1,
                (n > 0) && (n % (2 * H) == H), 1'b1};
      end
      1: return 3'b000;
      default: return {1'b1, mk == mt0, 1'b0};
    endcase
  endfunction

  task automatic cyc();
    @(posedge fpga_clk);
    model_edge();
    #2;
    check($sformatf("model k=%0d", mk),
          {clk_1Hz, tick, running}, exp_vec());
    if (tick === 1'b1) tick_cnt++;
    if (clk_1Hz === 1'b1) high_cnt++;
  endtask

  task automatic press_run();
    run_btn = 1'b1;
    repeat (6) cyc();
    run_btn = 1'b0;
  endtask

  task automatic press_step();
    step_btn = 1'b1;
    repeat (6) cyc();
    step_btn = 1'b0;
  endtask

  task automatic wait_run(input bit want, input int maxc,
                          input string nm);
    int c;
    c = 0;
    while (running !== want && c < maxc) begin
      cyc();
      c++;
    end
    check(nm, running, want);
  endtask

  task automatic first_rise(input string nm);
    int c;
    c = 0;
    do begin
      cyc();
      c++;
    end while (tick !== 1'b1 && c < 30);
    check(nm, c, H);
  endtask

  task automatic rst_pulse(input string nm);
    sys_init_ctrl = 1'b1;
    #1;
    check({nm, " async"}, {clk_1Hz, tick, running}, 3'b001);
    cyc();
    sys_init_ctrl = 1'b0;
    first_rise({nm, " first rise"});
  endtask

  initial begin
    int rc, sc;
    n_tests = 0; n_fail = 0;
    tick_cnt = 0; high_cnt = 0;
    sys_init_ctrl = 1'b1;
    run_btn = 1'b0;
    step_btn = 1'b0;
    model_reset();

    tbl[0] = '{0, 1, 30, 0, 1'b0};
    tbl[1] = '{0, 2, 30, 0, 1'b0};
    tbl[2] = '{0, 3, 30, 0, 1'b0};
    tbl[3] = '{0, 6, 40, 1, 1'b0};
    tbl[4] = '{6, 0, 40, 2, 1'b1};
    tbl[5] = '{0, 6, 34, 2, 1'b1};
    tbl[6] = '{6, 0, 30, 0, 1'b0};
    tbl[7] = '{6, 6, 30, 1, 1'b1};

    #1;
    check("reset outputs", {clk_1Hz, tick, running}, 3'b001);
    repeat (3) cyc();
    sys_init_ctrl = 1'b0;

    for (int k = 1; k <= 55; k++) begin
      bit ec, et;
      cyc();
      ec = (k >= 10 && k < 20) || (k >= 30 && k < 40) || (k >= 50);
      et = (k == 10) || (k == 30) || (k == 50);
      check($sformatf("boot k=%0d", k), {clk_1Hz, tick}, {ec, et});
    end

    press_run();
    wait_run(1'b0, 10, "pause entered");
    tick_cnt = 0; high_cnt = 0;
    repeat (100) cyc();
    check("pause ticks", tick_cnt, 0);
    check("pause highs", high_cnt, 0);
    press_run();
    wait_run(1'b1, 10, "resume entered");
    first_rise("resume first rise");
    press_run();
    wait_run(1'b0, 10, "pause again");

    tick_cnt = 0; high_cnt = 0;
    step_btn = 1'b1; repeat (4) cyc();
    step_btn = 1'b0; repeat (4) cyc();
    step_btn = 1'b1; repeat (4) cyc();
    step_btn = 1'b0; repeat (30) cyc();
    check("step ticks", tick_cnt, 1);
    check("step highs", high_cnt, H);
    check("step back paused", {running, clk_1Hz}, 2'b00);

    for (int v = 0; v < 8; v++) begin
      int n;
      n = (tbl[v].rl > tbl[v].sl ? tbl[v].rl : tbl[v].sl)
          + tbl[v].wt;
      tick_cnt = 0;
      for (int i = 0; i < n; i++) begin
        run_btn  = (i < tbl[v].rl);
        step_btn = (i < tbl[v].sl);
        cyc();
      end
      check($sformatf("vec%0d ticks", v), tick_cnt, tbl[v].ticks);
      check($sformatf("vec%0d running", v), running, tbl[v].run);
    end

    repeat (5) cyc();
    check("pre-reset high", clk_1Hz, 1'b1);
    rst_pulse("reset mid-high");

    press_run();
    wait_run(1'b0, 10, "pause before step");
    press_step();
    begin
      int c;
      c = 0;
      while (clk_1Hz !== 1'b1 && c < 10) begin
        cyc();
        c++;
      end
    end
    repeat (3) cyc();
    check("in step", {clk_1Hz, running}, 2'b10);
    rst_pulse("reset mid-step");

    run_btn = 1'b1;
    sys_init_ctrl = 1'b1;
    repeat (2) cyc();
    sys_init_ctrl = 1'b0;
    repeat (20) cyc();
    check("held through reset", running, 1'b1);
    run_btn = 1'b0;
    repeat (10) cyc();
    press_run();
    wait_run(1'b0, 10, "press after release");

    rc = 0; sc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rc > 0) rc--;
      else if ($urandom_range(0, 40) == 0) rc = $urandom_range(1, 9);
      if (sc > 0) sc--;
      else if ($urandom_range(0, 40) == 0) sc = $urandom_range(1, 9);
      run_btn = (rc > 0);
      step_btn = (sc > 0);
      sys_init_ctrl = ($urandom_range(0, 500) == 0);
      cyc();
    end
    sys_init_ctrl = 1'b0;
    run_btn = 1'b0;
    step_btn = 1'b0;
    repeat (5) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_timebase.md
TICK_TIMEBASE -- requirements
Module: tick_timebase

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: fpga_clk frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1: output square-wave frequency in Hz.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500_000: cycles a button level must stay stable to be accepted (10 ms at 50 MHz).
REQ-004 SHALL have port fpga_clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port sys_init_ctrl, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port run_btn, input, 1 bit: raw asynchronous pushbutton; each debounced press toggles between run and pause.
REQ-007 SHALL have port step_btn, input, 1 bit: raw asynchronous pushbutton; each debounced press while paused produces one period.
REQ-008 SHALL have port clk_1Hz, output, 1 bit: square-wave timebase level, registered; the downstream LED counter edge-detects it.
REQ-009 SHALL have port tick, output, 1 bit: single-cycle pulse, registered, in the cycle clk_1Hz rises.
REQ-010 SHALL have port running, output, 1 bit: high while the state is RUN.
REQ-011 One clock; reset is asynchronous and active-high.

Function
REQ-012 SHALL define HALF = CLK_HZ/(2*TICK_HZ) and fail elaboration if HALF < 2.
REQ-013 SHALL size the divider counter as clog2(HALF) bits, counting 0..HALF-1 with wrap to 0, never exceeding HALF-1.
REQ-014 SHALL implement states RUN, PAUSED and STEP.
REQ-015 In RUN, SHALL toggle clk_1Hz on each counter wrap, giving period 2*HALF cycles and exactly 50% duty.
REQ-016 SHALL assert tick for exactly the one cycle in which clk_1Hz changes 0->1, and at no other time.
REQ-017 On a run press in RUN, SHALL go to PAUSED, with clk_1Hz low and the counter 0 from the next cycle.
REQ-018 On a run press in PAUSED, SHALL go to RUN; the first clk_1Hz rise then occurs HALF cycles later.
REQ-019 On a step press in PAUSED, SHALL go to STEP, with clk_1Hz high and tick asserted in the next cycle.
REQ-020 In STEP, SHALL hold clk_1Hz high for HALF cycles, then return to PAUSED with clk_1Hz low and the counter 0.
REQ-021 SHALL ignore a step press in RUN or STEP, and a run press in STEP; presses are not queued.
REQ-022 If run and step presses occur in the same cycle in PAUSED, SHALL act on the run press only and ignore the step press.
REQ-023 SHALL hold the counter and clk_1Hz constant throughout PAUSED.
REQ-024 SHALL synchronise each button through 2 flip-flops before debouncing.
REQ-025 SHALL generate a press as a 1-cycle pulse on the debounced 0->1 transition; release generates nothing.
REQ-026 Total latency from a stable raw press to the press pulse SHALL be at most DEBOUNCE_CYCLES+3 cycles.
REQ-027 SHALL reject glitches shorter than DEBOUNCE_CYCLES, producing no press.

Reset
REQ-028 While sys_init_ctrl is high, SHALL immediately force: state RUN, counter 0, clk_1Hz 0, tick 0, running 1, debouncers idle (debounced level 0, stable counters 0).
REQ-029 Reset mid-period or mid-STEP SHALL abandon the period; the first rise after release occurs HALF cycles after the first active clock edge.
REQ-030 Buttons held through reset release SHALL NOT produce a press until released and pressed again.

Structure
REQ-031 SHALL place the state enum (RUN, PAUSED, STEP) and the HALF/width computation in the shared package tick_timebase_pkg.
REQ-032 SHALL implement synchroniser, debouncer and press pulse as one sub-module, btn_debounce_pulse (parameter DEBOUNCE_CYCLES), instantiated twice.

Verification (bench parameters: CLK_HZ=20, TICK_HZ=1 giving HALF=10; DEBOUNCE_CYCLES=4)
REQ-033 Reset release, no buttons -> clk_1Hz rises at cycles 10, 30, 50, falls at 20, 40; tick is high only at cycles 10, 30, 50; running=1.
REQ-034 Run press (held 6 cycles) in RUN -> running=0, clk_1Hz=0 and held for 100 cycles, tick never asserted; second run press -> first rise 10 cycles after the state change.
REQ-035 In PAUSED, step press -> clk_1Hz high for exactly 10 cycles, one tick, then low and PAUSED; step press during STEP -> no second tick.
REQ-036 Step button glitches of 1-3 cycles, and a step press in RUN -> no state change and unchanged tick timing.
REQ-037 Run and step raw edges identical in PAUSED -> enters RUN, no STEP, first tick 10 cycles later.
REQ-038 sys_init_ctrl asserted for 1 cycle mid-STEP and mid-high in RUN -> outputs reset asynchronously in the same cycle; next rise 10 cycles after release.
